// File: rtl/activation_unit_pkg.sv
// rtl/activation_unit_pkg.sv - shared constants and types for the activation datapath
package activation_unit_pkg;

    localparam int MATRIX_WIDTH = 14;
    localparam int ACC_WIDTH    = 32;
    localparam int BYTE_WIDTH   = 8;
    localparam int FRAC_BITS    = 8;

    typedef logic [3:0] ACTIVATION_BIT_TYPE;

    localparam ACTIVATION_BIT_TYPE ACT_NONE  = 4'b0000;
    localparam ACTIVATION_BIT_TYPE ACT_RELU  = 4'b0001;
    localparam ACTIVATION_BIT_TYPE ACT_RELU6 = 4'b0010;

    typedef logic [ACC_WIDTH-1:0]  ACC_ROW_TYPE  [MATRIX_WIDTH];
    typedef logic [BYTE_WIDTH-1:0] BYTE_ROW_TYPE [MATRIX_WIDTH];

endpackage

// File: rtl/activation_lane.sv
// rtl/activation_lane.sv - one lane: round, shift + activate, saturate (3 registers)
module activation_lane
    import activation_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic                  sign_s1,
    input  ACTIVATION_BIT_TYPE    func_s2,
    input  logic                  sign_s2,
    input  logic                  sign_s3,
    output logic [BYTE_WIDTH-1:0] act
);

    // One extra bit keeps the rounding add overflow-free in both modes.
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] HALF  = EW'(1) << (FRAC_BITS - 1);
    localparam logic signed [EW-1:0] ZERO  = EW'(0);
    localparam logic signed [EW-1:0] SIX   = EW'(6);
    localparam logic signed [EW-1:0] S_MAX = EW'(127);
    localparam logic signed [EW-1:0] S_MIN = EW'(-128);
    localparam logic signed [EW-1:0] U_MAX = EW'(255);

    logic signed [EW-1:0] ext, r1, r1_q, q, fn, fn_q;
    logic [BYTE_WIDTH-1:0] sat;

    always_comb begin
        ext = sign_s1 ? $signed({acc[ACC_WIDTH-1], acc}) : $signed({1'b0, acc});
        r1  = ext + HALF;
    end

    // Unsigned q is never negative, so the signed clamps below reduce to the unsigned rules.
    always_comb begin
        q  = sign_s2 ? (r1_q >>> FRAC_BITS) : $signed($unsigned(r1_q) >> FRAC_BITS);
        fn = q;
        case (func_s2)
            ACT_NONE:  fn = q;
            ACT_RELU:  fn = (q < ZERO) ? ZERO : q;
            ACT_RELU6: fn = (q < ZERO) ? ZERO : ((q > SIX) ? SIX : q);
            default:   fn = q;
        endcase
    end

    always_comb begin
        sat = fn_q[BYTE_WIDTH-1:0];
        if (sign_s3) begin
            if (fn_q > S_MAX)      sat = S_MAX[BYTE_WIDTH-1:0];
            else if (fn_q < S_MIN) sat = S_MIN[BYTE_WIDTH-1:0];
        end else begin
            if (fn_q > U_MAX)      sat = U_MAX[BYTE_WIDTH-1:0];
            else if (fn_q < ZERO)  sat = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r1_q <= '0;
            fn_q <= '0;
            act  <= '0;
        end else if (enable) begin
            r1_q <= r1;
            fn_q <= fn;
            act  <= sat;
        end
    end

endmodule

// File: rtl/activation_unit.sv
// rtl/activation_unit.sv - accumulator row to activated byte row, 3-stage pipeline
module activation_unit
    import activation_unit_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               valid_in,
    input  logic [MATRIX_WIDTH*ACC_WIDTH-1:0]  acc_data,
    input  ACTIVATION_BIT_TYPE                 activation_function,
    input  logic                               signed_not_unsigned,
    output logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] act_data,
    output logic                               valid_out
);

    ACC_ROW_TYPE        acc_row;
    BYTE_ROW_TYPE       act_row;
    logic [2:0]         valid_p;
    ACTIVATION_BIT_TYPE func_p1;
    logic               sign_p1, sign_p2;

    // Stage 1 uses the live inputs; later stages use the copies travelling with the row.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_p <= '0;
            func_p1 <= ACT_NONE;
            sign_p1 <= 1'b0;
            sign_p2 <= 1'b0;
        end else if (enable) begin
            valid_p <= {valid_p[1:0], valid_in};
            func_p1 <= activation_function;
            sign_p1 <= signed_not_unsigned;
            sign_p2 <= sign_p1;
        end
    end

    assign valid_out = valid_p[2];

    for (genvar i = 0; i < MATRIX_WIDTH; i++) begin : g_lane
        assign acc_row[i] = acc_data[i*ACC_WIDTH +: ACC_WIDTH];
        assign act_data[i*BYTE_WIDTH +: BYTE_WIDTH] = act_row[i];

        activation_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable),
            .acc     (acc_row[i]),
            .sign_s1 (signed_not_unsigned),
            .func_s2 (func_p1),
            .sign_s2 (sign_p1),
            .sign_s3 (sign_p2),
            .act     (act_row[i])
        );
    end

endmodule

// File: tb/tb_activation_unit.sv
// tb/tb_activation_unit.sv - scoreboard bench for activation_unit with a reference model
module tb_activation_unit;
    import activation_unit_pkg::*;

    localparam int MW = MATRIX_WIDTH;
    localparam int RW = MW * ACC_WIDTH;
    localparam int OW = MW * BYTE_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          valid_in = 1'b0;
    logic [RW-1:0] acc_data = '0;
    logic [3:0]    activation_function = 4'd0;
    logic          signed_not_unsigned = 1'b0;
    logic [OW-1:0] act_data;
    logic          valid_out;

    activation_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .valid_in            (valid_in),
        .acc_data            (acc_data),
        .activation_function (activation_function),
        .signed_not_unsigned (signed_not_unsigned),
        .act_data            (act_data),
        .valid_out           (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] row;
        int            edge_no;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            en_edges = 0;
    logic          was_rst, was_en;
    logic          model_valid = 1'b0;
    logic          model_known = 1'b0;
    logic [OW-1:0] model_data = '0;

    task automatic chk(input string name, input logic [OW-1:0] actual, input logic [OW-1:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, actual, required);
        end
    endtask

    // Round-half-up of acc/256, activation, then clamp to the output byte range.
    function automatic logic [7:0] exp_byte(input logic [31:0] a, input logic [3:0] f, input logic s);
        longint v, t, q;
        v = s ? longint'($signed(a)) : longint'({32'b0, a});
        t = v + 128;
        q = (t >= 0) ? t / 256 : -((-t + 255) / 256);
        if (s) begin
            if (f == 4'd1 && q < 0) q = 0;
            if (f == 4'd2) q = (q < 0) ? 0 : ((q > 6) ? 6 : q);
            if (q > 127)  q = 127;
            if (q < -128) q = -128;
        end else begin
            if (f == 4'd2 && q > 6) q = 6;
            if (q > 255) q = 255;
        end
        return q[7:0];
    endfunction

    function automatic logic [OW-1:0] exp_row(input logic [RW-1:0] a, input logic [3:0] f, input logic s);
        logic [OW-1:0] r;
        for (int i = 0; i < MW; i++) r[i*8 +: 8] = exp_byte(a[i*32 +: 32], f, s);
        return r;
    endfunction

    function automatic logic [RW-1:0] fill(input logic [31:0] v);
        logic [RW-1:0] r;
        for (int i = 0; i < MW; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        int k;
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: begin k = int'($urandom_range(0, 8191)) - 4096; return 32'(k); end
            2: begin k = (int'($urandom_range(0, 800)) - 400) * 256; return 32'(k); end
            default: begin k = (int'($urandom_range(0, 40)) - 20) * 256 + 128; return 32'(k); end
        endcase
    endfunction

    // Drive one cycle of inputs; a row is expected only if it will be sampled by an enabled edge.
    task automatic cyc(input logic v, input logic [RW-1:0] a, input logic [3:0] f,
                       input logic s, input logic en, input logic r);
        exp_t e;
        valid_in = v;
        acc_data = a;
        activation_function = f;
        signed_not_unsigned = s;
        enable = en;
        rst = r;
        if (v && en && r) begin
            e.row = exp_row(a, f, s);
            e.edge_no = en_edges + 1;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 4'd0, 1'b0, 1'b1, 1'b1);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        was_rst = !rst;
        was_en = enable;
        #1;
        if (was_rst) begin
            chk("reset_valid", OW'(valid_out), OW'(1'b0));
            chk("reset_data", act_data, '0);
            sb.delete();
            model_valid = 1'b0;
            model_known = 1'b1;
            model_data = '0;
        end else if (was_en) begin
            en_edges++;
            while (sb.size() > 0 && sb[0].edge_no + 2 < en_edges) begin
                e = sb.pop_front();
                chk("missed_row", OW'(1'b0), e.row);
            end
            model_valid = (sb.size() > 0 && sb[0].edge_no + 2 == en_edges);
            chk("valid_out", OW'(valid_out), OW'(model_valid));
            if (model_valid) begin
                e = sb.pop_front();
                chk("row_data", act_data, e.row);
                model_data = e.row;
                model_known = 1'b1;
            end else begin
                model_known = 1'b0;
            end
        end else begin
            chk("stall_valid", OW'(valid_out), OW'(model_valid));
            if (model_known) chk("stall_data", act_data, model_data);
        end
    end

    initial begin
        logic [RW-1:0] a;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Directed cases: rounding, RELU, saturation, RELU6 in both modes.
        cyc(1'b1, fill(32'h0000_0180), 4'd0, 1'b1, 1'b1, 1'b1);
        a = '0;
        a[31:0]  = 32'hFFFF_FE80;
        a[63:32] = 32'h0000_0280;
        cyc(1'b1, a, 4'd1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, a, 4'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, fill(32'h0001_0000), 4'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, fill(32'h0001_0000), 4'd0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, fill(32'hFF00_0000), 4'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, fill(32'h0000_0A00), 4'd2, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, fill(32'hFFFF_FF00), 4'd2, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, fill(32'hFFFF_FF00), 4'd0, 1'b0, 1'b1, 1'b1);
        idle(4);

        // Mixed codes back to back with a two-cycle stall carrying junk inputs.
        cyc(1'b1, fill(32'hFFFF_FD00), 4'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, fill(32'hFFFF_FD00), 4'd1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, fill(32'h0000_0900), 4'd2, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, fill(32'h1234_5678), 4'd1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, fill(32'h8765_4321), 4'd2, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, fill(32'h0000_0900), 4'd1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, fill(32'hFFFF_8000), 4'd0, 1'b0, 1'b1, 1'b1);
        idle(5);

        // Reset with three rows in flight; none may emerge afterwards.
        cyc(1'b1, fill(32'h0000_0300), 4'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, fill(32'h0000_0400), 4'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, fill(32'h0000_0500), 4'd0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, fill(32'h0000_0600), 4'd0, 1'b1, 1'b1, 1'b0);
        idle(6);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < MW; i++) a[i*32 +: 32] = rand_word();
            cyc($urandom_range(0, 3) != 0, a,
                ($urandom_range(0, 3) == 3) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0, $urandom_range(0, 99) != 0);
        end

        idle(8);
        chk("drain_empty", OW'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
